// File: rtl/riscv_trap_ctrl.sv
// Writeback trap/xRET redirect controller: picks the fetch PC source and drives pipeline flush.
// Zero-latency (Mealy) issue from IDLE; a request that meets an I-cache stall is held until the stall clears.
module riscv_trap_ctrl #(
   parameter int NUM_RET      = 2,
   parameter int RETW         = $clog2(NUM_RET + 1),  // derived; leave at default
   parameter int PCSEL_W      = 3,
   parameter int FLUSH_CYCLES = 1,
   parameter int HOLD_EN      = 1
) (
   input  logic               i_riscv_trapctl_clk,
   input  logic               i_riscv_trapctl_rst_n,
   input  logic               i_riscv_trapctl_gototrap,
   input  logic [RETW-1:0]    i_riscv_trapctl_returnfromtrap,
   input  logic               i_riscv_trapctl_icache_stall,
   output logic               o_riscv_trapctl_flush,
   output logic [PCSEL_W-1:0] o_riscv_trapctl_pcsel,
   output logic               o_riscv_trapctl_busy
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [PCSEL_W-1:0] TRAP_CODE = PCSEL_W'(1);

   typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

   state_t             state_q;
   logic [PCSEL_W-1:0] code_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               ret_ok;
   logic               req_vld;
   logic [PCSEL_W-1:0] req_code;

   assign ret_ok   = (i_riscv_trapctl_returnfromtrap != '0) &&
                     (int'(i_riscv_trapctl_returnfromtrap) <= NUM_RET);
   assign req_vld  = i_riscv_trapctl_gototrap || ret_ok;
   // Trap wins over a simultaneous xRET.
   assign req_code = i_riscv_trapctl_gototrap ? TRAP_CODE
                   : PCSEL_W'(i_riscv_trapctl_returnfromtrap) + PCSEL_W'(1);

   always_comb begin
      o_riscv_trapctl_flush = 1'b0;
      o_riscv_trapctl_pcsel = '0;
      o_riscv_trapctl_busy  = 1'b0;
      if (i_riscv_trapctl_rst_n) begin
         case (state_q)
            IDLE: begin
               if (req_vld && !i_riscv_trapctl_icache_stall) begin
                  o_riscv_trapctl_flush = 1'b1;
                  o_riscv_trapctl_pcsel = req_code;
               end
            end
            PEND: begin
               o_riscv_trapctl_busy = 1'b1;
               if (!i_riscv_trapctl_icache_stall) begin
                  o_riscv_trapctl_flush = 1'b1;
                  o_riscv_trapctl_pcsel = code_q;
               end
            end
            FLUSH: begin
               o_riscv_trapctl_flush = 1'b1;
               o_riscv_trapctl_busy  = 1'b1;
            end
            default: begin
               o_riscv_trapctl_flush = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_riscv_trapctl_clk or negedge i_riscv_trapctl_rst_n) begin
      if (!i_riscv_trapctl_rst_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_vld) begin
                  if (!i_riscv_trapctl_icache_stall) begin
                     if (FLUSH_CYCLES > 1) begin
                        state_q <= FLUSH;
                        cnt_q   <= CNT_INIT;
                     end
                  end else if (HOLD_EN != 0) begin
                     state_q <= PEND;
                     code_q  <= req_code;
                  end
               end
            end
            PEND: begin
               if (i_riscv_trapctl_icache_stall) begin
                  // A late trap supersedes a held xRET; later xRETs are ignored.
                  if (i_riscv_trapctl_gototrap)
                     code_q <= TRAP_CODE;
               end else begin
                  code_q <= '0;
                  if (FLUSH_CYCLES > 1) begin
                     state_q <= FLUSH;
                     cnt_q   <= CNT_INIT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            FLUSH: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1))
                  state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Randomised and directed bench for riscv_trap_ctrl across three parameter sets, checked against a
// transaction-level model (pending request / remaining flush cycles) plus literal expectations.
module tb_riscv_trap_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       gototrap;
   logic [1:0] ret;
   logic       stall;

   logic [2:0] dflush;
   logic [2:0] dbusy;
   logic [2:0] dpcsel [3];

   int checks = 0;
   int errors = 0;

   // Instance configurations: u0 defaults, u1 NUM_RET=3/FLUSH=3, u2 HOLD off/FLUSH=2.
   int nr [3] = '{2, 3, 2};
   int fc [3] = '{1, 3, 2};
   int he [3] = '{1, 1, 0};

   // Model state: pending request held, its pcsel code, flush cycles still owed after issue.
   int pv  [3] = '{0, 0, 0};
   int pcd [3] = '{0, 0, 0};
   int fl  [3] = '{0, 0, 0};

   always #5 clk = ~clk;

   riscv_trap_ctrl #(.NUM_RET(2), .PCSEL_W(3), .FLUSH_CYCLES(1), .HOLD_EN(1)) u0 (
      .i_riscv_trapctl_clk(clk), .i_riscv_trapctl_rst_n(rst_n),
      .i_riscv_trapctl_gototrap(gototrap), .i_riscv_trapctl_returnfromtrap(ret),
      .i_riscv_trapctl_icache_stall(stall), .o_riscv_trapctl_flush(dflush[0]),
      .o_riscv_trapctl_pcsel(dpcsel[0]), .o_riscv_trapctl_busy(dbusy[0]));

   riscv_trap_ctrl #(.NUM_RET(3), .PCSEL_W(3), .FLUSH_CYCLES(3), .HOLD_EN(1)) u1 (
      .i_riscv_trapctl_clk(clk), .i_riscv_trapctl_rst_n(rst_n),
      .i_riscv_trapctl_gototrap(gototrap), .i_riscv_trapctl_returnfromtrap(ret),
      .i_riscv_trapctl_icache_stall(stall), .o_riscv_trapctl_flush(dflush[1]),
      .o_riscv_trapctl_pcsel(dpcsel[1]), .o_riscv_trapctl_busy(dbusy[1]));

   riscv_trap_ctrl #(.NUM_RET(2), .PCSEL_W(3), .FLUSH_CYCLES(2), .HOLD_EN(0)) u2 (
      .i_riscv_trapctl_clk(clk), .i_riscv_trapctl_rst_n(rst_n),
      .i_riscv_trapctl_gototrap(gototrap), .i_riscv_trapctl_returnfromtrap(ret),
      .i_riscv_trapctl_icache_stall(stall), .o_riscv_trapctl_flush(dflush[2]),
      .o_riscv_trapctl_pcsel(dpcsel[2]), .o_riscv_trapctl_busy(dbusy[2]));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model compare: inputs change at negedge, outputs are checked 2ns later, model advances
   // as if the following posedge had consumed the same inputs.
   always @(negedge clk) begin
      #2;
      for (int i = 0; i < 3; i++) begin
         int e_fl, e_pc, e_bs, req, code;
         e_fl = 0; e_pc = 0; e_bs = 0;
         req  = (gototrap == 1'b1) || (ret >= 1 && int'(ret) <= nr[i]);
         code = gototrap ? 1 : 1 + int'(ret);
         if (rst_n) begin
            if (fl[i] > 0) begin
               e_fl = 1; e_bs = 1;
            end else if (pv[i] != 0) begin
               e_bs = 1;
               if (!stall) begin e_fl = 1; e_pc = pcd[i]; end
            end else if (req != 0 && !stall) begin
               e_fl = 1; e_pc = code;
            end
         end
         chk($sformatf("u%0d_flush", i), int'(dflush[i]), e_fl);
         chk($sformatf("u%0d_pcsel", i), int'(dpcsel[i]), e_pc);
         chk($sformatf("u%0d_busy", i),  int'(dbusy[i]),  e_bs);
         if (!rst_n) begin
            pv[i] = 0; pcd[i] = 0; fl[i] = 0;
         end else if (fl[i] > 0) begin
            fl[i] = fl[i] - 1;
         end else if (pv[i] != 0) begin
            if (stall) begin
               if (gototrap) pcd[i] = 1;
            end else begin
               pv[i] = 0; fl[i] = fc[i] - 1;
            end
         end else if (req != 0) begin
            if (!stall) fl[i] = fc[i] - 1;
            else if (he[i] != 0) begin pv[i] = 1; pcd[i] = code; end
         end
      end
   end

   task automatic step(input logic r, input logic g, input logic [1:0] rt, input logic s);
      @(negedge clk);
      rst_n = r; gototrap = g; ret = rt; stall = s;
      #3;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'd0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; gototrap = 1'b0; ret = 2'd0; stall = 1'b0;
      // Reset: outputs forced low even with a request present.
      step(1'b0, 1'b1, 2'd2, 1'b0);
      chk("rst_flush", int'(dflush[0]), 0);
      chk("rst_pcsel", int'(dpcsel[0]), 0);
      idle(2);

      // Trap beats return, zero latency; u1 stretches flush over 3 cycles ignoring requests.
      step(1'b1, 1'b1, 2'd2, 1'b0);
      chk("t1_pcsel", int'(dpcsel[0]), 1);
      chk("t1_flush", int'(dflush[0]), 1);
      chk("t1_busy",  int'(dbusy[0]),  0);
      chk("t4_pcsel_c1", int'(dpcsel[1]), 1);
      step(1'b1, 1'b0, 2'd1, 1'b0);
      chk("t4_flush_c2", int'(dflush[1]), 1);
      chk("t4_pcsel_c2", int'(dpcsel[1]), 0);
      chk("t1_ret_after", int'(dpcsel[0]), 2);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk("t1_idle_flush", int'(dflush[0]), 0);
      chk("t4_flush_c3", int'(dflush[1]), 1);
      chk("t4_busy_c3",  int'(dbusy[1]),  1);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk("t4_flush_c4", int'(dflush[1]), 0);
      chk("t4_busy_c4",  int'(dbusy[1]),  0);
      idle(2);

      // Held return across a 4-cycle stall.
      step(1'b1, 1'b0, 2'd1, 1'b1);
      chk("t2_c1_busy", int'(dbusy[0]), 0);
      chk("t2_c1_flush", int'(dflush[0]), 0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 2'd0, 1'b1);
         chk("t2_stall_busy", int'(dbusy[0]), 1);
         chk("t2_stall_pcsel", int'(dpcsel[0]), 0);
      end
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk("t2_rel_pcsel", int'(dpcsel[0]), 2);
      chk("t2_rel_flush", int'(dflush[0]), 1);
      chk("t2_rel_busy",  int'(dbusy[0]),  1);
      chk("t2_drop_pcsel", int'(dpcsel[2]), 0);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk("t2_after_busy", int'(dbusy[0]), 0);
      idle(3);

      // Trap overrides a held xRET during the stall.
      step(1'b1, 1'b0, 2'd2, 1'b1);
      step(1'b1, 1'b1, 2'd0, 1'b1);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk("t3_pcsel", int'(dpcsel[0]), 1);
      idle(3);

      // HOLD_EN=0 drops a stalled request.
      step(1'b1, 1'b0, 2'd2, 1'b1);
      chk("t5_c1_flush", int'(dflush[2]), 0);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk("t5_c2_flush", int'(dflush[2]), 0);
      chk("t5_c2_pcsel", int'(dpcsel[2]), 0);
      chk("t5_hold_pcsel", int'(dpcsel[0]), 3);
      idle(3);

      // Back-to-back on u2 (FLUSH_CYCLES=2): new trap right after the last flush cycle.
      step(1'b1, 1'b1, 2'd0, 1'b0);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b1, 2'd0, 1'b0);
      chk("b2b_pcsel", int'(dpcsel[2]), 1);
      idle(3);

      // Return kind 3 exists only on u1; reset in PEND loses the held request.
      step(1'b1, 1'b0, 2'd3, 1'b0);
      chk("t6_k3_pcsel", int'(dpcsel[1]), 4);
      chk("t6_k3_u0", int'(dflush[0]), 0);
      idle(3);
      step(1'b1, 1'b0, 2'd3, 1'b1);
      step(1'b1, 1'b0, 2'd0, 1'b1);
      chk("t6_pend_busy", int'(dbusy[1]), 1);
      step(1'b0, 1'b0, 2'd0, 1'b1);
      chk("t6_rst_busy", int'(dbusy[1]), 0);
      chk("t6_rst_flush", int'(dflush[1]), 0);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk("t6_post_pcsel", int'(dpcsel[1]), 0);
      chk("t6_post_flush", int'(dflush[1]), 0);
      idle(2);

      // Random traffic, occasional async reset.
      for (int k = 0; k < 4000; k++) begin
         step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
